mont_const_gen: RTL and testbench

//  Parametrised generator of the Montgomery constants for an odd modulus p.

---
 rtl/mont_pkg.sv | 18 +
 rtl/mod_dbl_sub.sv | 19 +
 rtl/mont_const_gen.sv | 104 ++++++++++
 tb/tb_mont_const_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared types and defaults for the Montgomery constant generator
package mont_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH       = 1040;
    localparam int DEFAULT_STEP_CYCLES = 16;

    // Counter width that stays at least one bit for tiny ranges.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/mod_dbl_sub.sv
// rtl/mod_dbl_sub.sv - combinational modular doubling step: next_r = 2r mod p, given r < p
module mod_dbl_sub #(
    parameter int WIDTH = 1040
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] next_r
);

    logic [WIDTH:0] dbl;
    logic [WIDTH:0] diff;

    assign dbl  = {r, 1'b0};
    // 2r < 2p, so the WIDTH+1-bit difference's top bit is an exact borrow flag.
    assign diff = dbl - {1'b0, p};

    assign next_r = diff[WIDTH] ? dbl[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/mont_const_gen.sv
// rtl/mont_const_gen.sv - computes R mod p or R^2 mod p (R = 2^WIDTH) by iterated modular doubling
module mont_const_gen
    import mont_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int STEP_CYCLES = DEFAULT_STEP_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sq,
    input  logic [WIDTH-1:0] prime,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int ITER_W   = $clog2(2 * WIDTH + 1);
    localparam int SETTLE_W = clog2_min1(STEP_CYCLES);

    localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = SETTLE_W'(STEP_CYCLES - 1);
    localparam logic [ITER_W-1:0]   ITER_SQ       = ITER_W'(2 * WIDTH);
    localparam logic [ITER_W-1:0]   ITER_LIN      = ITER_W'(WIDTH);

    state_t              state;
    logic [WIDTH-1:0]    p_reg;
    logic [WIDTH-1:0]    r;
    logic [WIDTH-1:0]    next_r;
    logic [ITER_W-1:0]   iter_cnt;
    logic [SETTLE_W-1:0] settle;

    // r and p_reg stay frozen while settle counts down, giving the subtractor
    // STEP_CYCLES clocks to resolve.
    mod_dbl_sub #(
        .WIDTH (WIDTH)
    ) u_mod_dbl_sub (
        .r      (r),
        .p      (p_reg),
        .next_r (next_r)
    );

    assign result = r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            p_reg    <= '0;
            r        <= '0;
            iter_cnt <= '0;
            settle   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg <= prime;
                        valid <= 1'b0;
                        err   <= 1'b0;
                        if (!prime[0] || (prime < WIDTH'(3))) begin
                            r     <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            r        <= WIDTH'(1);
                            iter_cnt <= sq ? ITER_SQ : ITER_LIN;
                            settle   <= SETTLE_RELOAD;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (settle != '0) begin
                        settle <= settle - SETTLE_W'(1);
                    end else begin
                        r        <= next_r;
                        iter_cnt <= iter_cnt - ITER_W'(1);
                        settle   <= SETTLE_RELOAD;
                        if (iter_cnt == ITER_W'(1)) begin
                            busy  <= 1'b0;
                            valid <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_const_gen.sv
// tb/tb_mont_const_gen.sv - randomized self-checking bench for mont_const_gen against a modular-exponent model
module tb_mont_const_gen;

    localparam int WW = 1040;

    logic clk;
    logic rst_n;

    logic       start8  [2];
    logic       sq8     [2];
    logic [7:0] prime8  [2];
    logic       busy8   [2];
    logic       done8   [2];
    logic       valid8  [2];
    logic       err8    [2];
    logic [7:0] result8 [2];

    logic          start_w, sq_w, busy_w, done_w, valid_w, err_w;
    logic [WW-1:0] prime_w, result_w;

    int tests_run;
    int tests_failed;

    mont_const_gen #(.WIDTH(8), .STEP_CYCLES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start8[0]), .sq(sq8[0]), .prime(prime8[0]),
        .busy(busy8[0]), .done(done8[0]), .valid(valid8[0]), .err(err8[0]), .result(result8[0])
    );

    mont_const_gen #(.WIDTH(8), .STEP_CYCLES(4)) dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start8[1]), .sq(sq8[1]), .prime(prime8[1]),
        .busy(busy8[1]), .done(done8[1]), .valid(valid8[1]), .err(err8[1]), .result(result8[1])
    );

    mont_const_gen dut_wide (
        .clk(clk), .rst_n(rst_n), .start(start_w), .sq(sq_w), .prime(prime_w),
        .busy(busy_w), .done(done_w), .valid(valid_w), .err(err_w), .result(result_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [259:0] got, input logic [259:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: 2^WIDTH or 2^(2*WIDTH) reduced modulo p directly.
    function automatic logic [7:0] ref_mod8(input logic [7:0] p, input logic s);
        longint pw;
        pw = s ? 64'd65536 : 64'd256;
        return 8'(pw % longint'(p));
    endfunction

    task automatic op8(input int i, input logic [7:0] p, input logic s, input bit poke);
        int step, iters, lat, explat, changes, offgrid;
        bit bad, busy_seen;
        logic [7:0] exp_r, prev;
        step   = (i == 0) ? 1 : 4;
        iters  = s ? 16 : 8;
        bad    = (p[0] == 1'b0) || (p < 8'd3);
        exp_r  = bad ? 8'd0 : ref_mod8(p, s);
        explat = bad ? 0 : iters * step;
        @(negedge clk);
        start8[i] = 1'b1;
        prime8[i] = p;
        sq8[i]    = s;
        @(posedge clk);
        @(negedge clk);
        start8[i] = 1'b0;
        prime8[i] = 8'($urandom);
        sq8[i]    = 1'($urandom);
        lat = 0; changes = 0; offgrid = 0;
        busy_seen = busy8[i];
        prev = result8[i];
        while (!done8[i] && lat < 400) begin
            @(negedge clk);
            lat++;
            start8[i] = 1'b0;
            if (poke && lat == 2) begin
                start8[i] = 1'b1;
                prime8[i] = p ^ 8'h02;
            end
            busy_seen = busy_seen | busy8[i];
            if (result8[i] != prev) begin
                changes++;
                if (lat % step != 0) offgrid++;
            end
            prev = result8[i];
        end
        start8[i] = 1'b0;
        check("latency",   260'(lat),          260'(explat));
        check("result",    260'(result8[i]),   260'(exp_r));
        check("valid",     260'(valid8[i]),    260'(!bad));
        check("err",       260'(err8[i]),      260'(bad));
        check("busy_seen", 260'(busy_seen),    260'(!bad));
        check("steps",     260'(changes),      260'(bad ? 0 : iters));
        check("offgrid",   260'(offgrid),      260'(0));
        @(negedge clk);
        check("done_pulse", 260'(done8[i]),    260'(0));
        check("busy_after", 260'(busy8[i]),    260'(0));
        repeat (3) @(negedge clk);
        check("hold_result", 260'(result8[i]), 260'(exp_r));
        check("hold_valid",  260'(valid8[i]),  260'(!bad));
    endtask

    task automatic op_wide(input logic [WW-1:0] p);
        logic [2*WW:0] pw, pm;
        logic [WW-1:0] exp_r;
        int lat;
        pw = '0;
        pw[2*WW] = 1'b1;
        pm = pw % {{(WW+1){1'b0}}, p};
        exp_r = pm[WW-1:0];
        @(negedge clk);
        start_w = 1'b1;
        sq_w    = 1'b1;
        prime_w = p;
        @(posedge clk);
        @(negedge clk);
        start_w = 1'b0;
        prime_w = '0;
        lat = 0;
        while (!done_w && lat < 40000) begin
            @(negedge clk);
            lat++;
        end
        check("wide_latency", 260'(lat), 260'(33280));
        for (int j = 0; j < 4; j++)
            check("wide_result", result_w[j*260 +: 260], exp_r[j*260 +: 260]);
        check("wide_valid", 260'(valid_w), 260'(1));
        check("wide_err",   260'(err_w),   260'(0));
    endtask

    initial begin
        logic [1055:0] wide_tmp;
        logic [7:0]    rp;
        bit            done_seen;
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start8[i] = 1'b0; sq8[i] = 1'b0; prime8[i] = '0;
        end
        start_w = 1'b0; sq_w = 1'b0; prime_w = '0;

        repeat (3) @(negedge clk);
        check("rst_result", 260'(result8[0]), 260'(0));
        check("rst_flags",  260'({busy8[0], done8[0], valid8[0], err8[0]}), 260'(0));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_autostart", 260'({busy_w, busy8[1], busy8[0]}), 260'(0));

        op8(0, 8'd251, 1'b0, 1'b0);
        op8(0, 8'd251, 1'b1, 1'b0);
        op8(0, 8'd13,  1'b1, 1'b0);
        op8(0, 8'd13,  1'b0, 1'b0);
        op8(1, 8'd13,  1'b1, 1'b0);
        op8(0, 8'd250, 1'b0, 1'b0);
        op8(0, 8'd1,   1'b1, 1'b0);
        op8(0, 8'd251, 1'b1, 1'b1);

        for (int n = 0; n < 12; n++) begin
            rp = 8'($urandom);
            if (n % 4 != 0) rp[0] = 1'b1;
            op8(n % 2, rp, 1'($urandom), bit'(n % 3 == 1));
        end

        // Abort mid-operation via reset.
        @(negedge clk);
        start8[0] = 1'b1; prime8[0] = 8'd251; sq8[0] = 1'b1;
        @(negedge clk);
        start8[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", 260'(busy8[0]), 260'(1));
        rst_n = 1'b0;
        #1;
        check("abort_result", 260'(result8[0]), 260'(0));
        check("abort_flags",  260'({busy8[0], done8[0], valid8[0], err8[0]}), 260'(0));
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            done_seen = done_seen | done8[0];
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            done_seen = done_seen | done8[0] | busy8[0];
        end
        check("abort_no_done", 260'(done_seen), 260'(0));

        wide_tmp = '0;
        for (int j = 0; j < 33; j++) wide_tmp[j*32 +: 32] = $urandom;
        wide_tmp[0] = 1'b1;
        wide_tmp[WW-1] = 1'b1;
        op_wide(wide_tmp[WW-1:0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
